// File: rtl/fib_arbiter.sv
// fib_arbiter: round-robin front end that shares one Fibonacci unit among
// NUM_REQ requesters. It grants one requester at a time, latches that
// requester's n, pulses the unit's go, and waits for the old done to clear
// and then for the new done. It returns the result tagged with the
// requester id. A timeout ends a job the unit never finishes.
//
// Ports
//   clk, rst_n     : clock (rising edge) and async active-low reset
//   req            : level request per requester, held until its resp_valid
//   req_n          : packed n per requester, slice i at [i*INPUT_WIDTH +: INPUT_WIDTH]
//   resp_valid     : one-cycle pulse, response fields valid
//   resp_id        : requester owning the response
//   resp_result    : Fibonacci result (0 on timeout)
//   resp_overflow  : overflow flag from the unit (0 on timeout)
//   resp_error     : job ended by timeout
//   busy           : high whenever not IDLE
//   fib_go, fib_n  : request to the Fibonacci unit
//   fib_result, fib_overflow, fib_done : response from the Fibonacci unit
module fib_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int INPUT_WIDTH    = 6,
    parameter int OUTPUT_WIDTH   = 32,
    parameter int TIMEOUT_CYCLES = 1024,
    localparam int ID_W          = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    localparam int CNT_W         = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_REQ-1:0]             req,
    input  logic [NUM_REQ*INPUT_WIDTH-1:0] req_n,
    output logic                           resp_valid,
    output logic [ID_W-1:0]                resp_id,
    output logic [OUTPUT_WIDTH-1:0]        resp_result,
    output logic                           resp_overflow,
    output logic                           resp_error,
    output logic                           busy,
    output logic                           fib_go,
    output logic [INPUT_WIDTH-1:0]         fib_n,
    input  logic [OUTPUT_WIDTH-1:0]        fib_result,
    input  logic                           fib_overflow,
    input  logic                           fib_done
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ISSUE     = 3'd1,
        WAIT_CLR  = 3'd2,
        WAIT_DONE = 3'd3,
        RESP      = 3'd4
    } state_t;

    state_t                  state, state_next;
    logic [ID_W-1:0]         ptr;
    logic [ID_W-1:0]         id_lat;
    logic [INPUT_WIDTH-1:0]  n_lat;
    logic [CNT_W-1:0]        tmo_cnt;

    logic                    gnt_found;
    logic [ID_W-1:0]         gnt_id;
    logic [INPUT_WIDTH-1:0]  gnt_n;
    logic                    waiting;
    logic                    tmo_hit;
    logic                    complete;
    logic                    timed_out;
    int                      idx;

    // Round-robin search: first set request at or after ptr, wrapping.
    always_comb begin
        gnt_found = 1'b0;
        gnt_id    = '0;
        gnt_n     = '0;
        idx       = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!gnt_found && req[idx]) begin
                gnt_found = 1'b1;
                gnt_id    = ID_W'(idx);
                gnt_n     = req_n[idx*INPUT_WIDTH +: INPUT_WIDTH];
            end
        end
    end

    assign waiting   = (state == WAIT_CLR) || (state == WAIT_DONE);
    assign tmo_hit   = waiting && (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    // Only a done seen after it has first dropped counts as completion, so
    // the previous job's done is never mistaken for this one's.
    assign complete  = (state == WAIT_DONE) && fib_done;
    assign timed_out = tmo_hit && !complete;

    always_comb begin
        state_next = state;
        case (state)
            IDLE:      if (gnt_found) state_next = ISSUE;
            ISSUE:     state_next = WAIT_CLR;
            WAIT_CLR:  if (timed_out) state_next = RESP;
                       else if (!fib_done) state_next = WAIT_DONE;
            WAIT_DONE: if (complete || timed_out) state_next = RESP;
            RESP:      state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr           <= '0;
            id_lat        <= '0;
            n_lat         <= '0;
            tmo_cnt       <= '0;
            resp_valid    <= 1'b0;
            resp_id       <= '0;
            resp_result   <= '0;
            resp_overflow <= 1'b0;
            resp_error    <= 1'b0;
        end else begin
            if (state == IDLE && gnt_found) begin
                id_lat <= gnt_id;
                n_lat  <= gnt_n;
                ptr    <= (gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id + 1'b1;
            end

            if (state == ISSUE)  tmo_cnt <= '0;
            else if (waiting)    tmo_cnt <= tmo_cnt + 1'b1;

            resp_valid <= complete || timed_out;
            if (complete) begin
                resp_id       <= id_lat;
                resp_result   <= fib_result;
                resp_overflow <= fib_overflow;
                resp_error    <= 1'b0;
            end else if (timed_out) begin
                resp_id       <= id_lat;
                resp_result   <= '0;
                resp_overflow <= 1'b0;
                resp_error    <= 1'b1;
            end
        end
    end

    assign fib_go = (state == ISSUE);
    assign fib_n  = n_lat;
    assign busy   = (state != IDLE);

endmodule

// File: tb/tb_fib_arbiter.sv
// Self-checking bench for fib_arbiter with a behavioural Fibonacci stub:
// done drops stub_clr cycles after go, then rises stub_clr+stub_lat cycles
// after go with result n+100 (never rises when stub_hang is set).
module tb_fib_arbiter;
    localparam int N  = 4;
    localparam int IW = 6;
    localparam int OW = 32;
    localparam int TO = 16;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    req = '0;
    logic [N*IW-1:0] req_n = '0;
    logic            resp_valid;
    logic [1:0]      resp_id;
    logic [OW-1:0]   resp_result;
    logic            resp_overflow;
    logic            resp_error;
    logic            busy;
    logic            fib_go;
    logic [IW-1:0]   fib_n;
    logic [OW-1:0]   fib_result;
    logic            fib_overflow;
    logic            fib_done;

    fib_arbiter #(.NUM_REQ(N), .INPUT_WIDTH(IW), .OUTPUT_WIDTH(OW), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_n(req_n),
        .resp_valid(resp_valid), .resp_id(resp_id), .resp_result(resp_result),
        .resp_overflow(resp_overflow), .resp_error(resp_error), .busy(busy),
        .fib_go(fib_go), .fib_n(fib_n), .fib_result(fib_result),
        .fib_overflow(fib_overflow), .fib_done(fib_done)
    );

    always #5 clk = ~clk;

    // ---------------- Fibonacci stub ----------------
    int            stub_lat  = 5;
    int            stub_clr  = 1;
    bit            stub_hang = 1'b0;
    bit            stub_ovf  = 1'b0;
    int            t = 0;
    logic [IW-1:0] n_s = '0;
    logic [OW-1:0] old_res = 32'hDEAD_BEEF;
    logic          old_ovf = 1'b0;
    logic          jdone;

    always @(posedge clk) begin
        if (fib_go) begin
            t       <= 1;
            n_s     <= fib_n;
            old_res <= fib_result;
            old_ovf <= fib_overflow;
        end else if (t != 0 && t < 1000) begin
            t <= t + 1;
        end
    end

    assign jdone        = (t != 0) && !stub_hang && (t >= stub_clr + stub_lat);
    assign fib_done     = (t == 0) || (t < stub_clr) || jdone;
    assign fib_result   = jdone ? (OW'(n_s) + 32'd100) : old_res;
    assign fib_overflow = jdone ? stub_ovf : old_ovf;

    // ---------------- scoreboard ----------------
    typedef struct {
        int            id;
        logic [OW-1:0] res;
        bit            ovf;
        bit            err;
    } exp_t;

    typedef struct {
        int id;
        int n;
        int lat;
        int clr;
        bit ovf;
        int exp_res;
        bit exp_ovf;
    } vec_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    bit   inflight = 1'b0;
    bit   got = 1'b0;
    bit   go_seen = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push(input int id, input int res, input bit ovf, input bit err);
        exp_t e;
        e.id = id; e.res = res; e.ovf = ovf; e.err = err;
        sb.push_back(e);
    endtask

    task automatic set_n(input int id, input int n);
        req_n[id*IW +: IW] = IW'(n);
    endtask

    // One cycle; samples outputs on the falling edge and scores responses.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        got     = 1'b0;
        go_seen = 1'b0;
        if (rst_n) begin
            if (fib_go) begin
                go_seen = 1'b1;
                check("go_while_job_in_flight", 32'(inflight), 32'd0);
                inflight = 1'b1;
            end
            if (resp_valid) begin
                got      = 1'b1;
                inflight = 1'b0;
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_resp: got id %0d result %0d expected no response", resp_id, resp_result);
                end else begin
                    e = sb.pop_front();
                    check("resp_id", 32'(resp_id), 32'(e.id));
                    check("resp_result", resp_result, e.res);
                    check("resp_overflow", 32'(resp_overflow), 32'(e.ovf));
                    check("resp_error", 32'(resp_error), 32'(e.err));
                end
            end
        end
    endtask

    task automatic wait_resp();
        for (int i = 0; i < 300; i++) begin
            tick();
            if (got) return;
        end
        checks++;
        errors++;
        $display("FAIL resp_timeout: got no resp_valid in 300 cycles expected one");
    endtask

    vec_t vecs[4];

    initial begin
        int k;
        vecs[0] = '{id: 0, n: 10, lat: 5, clr: 1, ovf: 1'b0, exp_res: 110, exp_ovf: 1'b0};
        vecs[1] = '{id: 1, n: 63, lat: 3, clr: 2, ovf: 1'b0, exp_res: 163, exp_ovf: 1'b0};
        vecs[2] = '{id: 3, n: 0,  lat: 1, clr: 3, ovf: 1'b1, exp_res: 100, exp_ovf: 1'b1};
        vecs[3] = '{id: 2, n: 33, lat: 7, clr: 1, ovf: 1'b0, exp_res: 133, exp_ovf: 1'b0};

        // Reset values
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_fib_go", 32'(fib_go), 32'd0);
        check("rst_fib_n", 32'(fib_n), 32'd0);
        check("rst_resp_id", 32'(resp_id), 32'd0);
        check("rst_resp_result", resp_result, 32'd0);
        check("rst_resp_overflow", 32'(resp_overflow), 32'd0);
        check("rst_resp_error", 32'(resp_error), 32'd0);
        rst_n = 1'b1;
        tick();

        // Single-requester jobs, including stale-done windows and overflow
        for (int v = 0; v < 4; v++) begin
            stub_lat = vecs[v].lat;
            stub_clr = vecs[v].clr;
            stub_ovf = vecs[v].ovf;
            push(vecs[v].id, vecs[v].exp_res, vecs[v].exp_ovf, 1'b0);
            set_n(vecs[v].id, vecs[v].n);
            req[vecs[v].id] = 1'b1;
            wait_resp();
            req[vecs[v].id] = 1'b0;
            tick();
        end

        // Timeout: unit never completes
        stub_hang = 1'b1; stub_clr = 1; stub_ovf = 1'b0;
        push(2, 0, 1'b0, 1'b1);
        set_n(2, 5);
        req[2] = 1'b1;
        for (int i = 0; i < 20 && !go_seen; i++) tick();
        if (!go_seen) begin
            checks++; errors++;
            $display("FAIL timeout_go: got no fib_go expected one");
        end
        k = 0;
        got = 1'b0;
        while (!got && k < 100) begin
            tick();
            k++;
        end
        check("timeout_latency", 32'(k), 32'd17);
        req[2] = 1'b0;
        stub_hang = 1'b0;
        tick();

        // Normal job after timeout
        stub_lat = 4;
        push(1, 120, 1'b0, 1'b0);
        set_n(1, 20);
        req[1] = 1'b1;
        wait_resp();
        req[1] = 1'b0;
        tick();

        // Reset mid-job: no response, busy drops at once
        stub_lat = 10;
        set_n(1, 9);
        req[1] = 1'b1;
        for (int i = 0; i < 20 && !go_seen; i++) tick();
        repeat (3) tick();
        rst_n = 1'b0;
        #1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_fib_go", 32'(fib_go), 32'd0);
        check("midrst_resp_valid", 32'(resp_valid), 32'd0);
        repeat (2) tick();
        req[1] = 1'b0;
        rst_n = 1'b1;
        inflight = 1'b0;
        repeat (12) tick();
        check("idle_after_rst_busy", 32'(busy), 32'd0);

        // All four requesting: grant order 0,1,2,3,0
        stub_lat = 3; stub_clr = 1;
        for (int i = 0; i < N; i++) set_n(i, i);
        push(0, 100, 0, 0); push(1, 101, 0, 0); push(2, 102, 0, 0);
        push(3, 103, 0, 0); push(0, 100, 0, 0);
        req = 4'b1111;
        for (int j = 0; j < 5; j++) wait_resp();
        req = 4'b0000;
        tick();

        // Fairness: req0 and req2 both high, pointer at 1 -> 2 then 0
        push(2, 102, 0, 0); push(0, 100, 0, 0);
        req = 4'b0101;
        wait_resp();
        req[2] = 1'b0;
        wait_resp();
        req = 4'b0000;
        tick();

        // Pointer wrap: grant 3 leaves pointer at 0, then 0 before 1
        push(3, 103, 0, 0);
        req = 4'b1000;
        wait_resp();
        req = 4'b0000;
        tick();
        push(0, 100, 0, 0); push(1, 101, 0, 0);
        req = 4'b0011;
        wait_resp();
        req[0] = 1'b0;
        wait_resp();
        req = 4'b0000;
        repeat (5) tick();

        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fib_arbiter.md
Name: fib_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one Fibonacci calculator (the go/n/result/overflow/done unit) among NUM_REQ requesters.
- Latches a requester's n, pulses the unit's go and waits through the done-clear and done-set phases.
- Returns result/overflow tagged with the requester id, with a timeout guard against a hung unit.
- Sits between client logic and a single fib instance.

Parameters:
NUM_REQ, 4, number of requesters (2..16)
INPUT_WIDTH, 6, width of n, matches fib unit
OUTPUT_WIDTH, 32, width of result, matches fib unit
TIMEOUT_CYCLES, 1024, max cycles from go to done before error (>=4)

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  asynchronous, active-low reset
req  in  NUM_REQ  level request per requester; held until its resp_valid
req_n  in  NUM_REQ*INPUT_WIDTH  packed n per requester; slice i = bits [i*INPUT_WIDTH +: INPUT_WIDTH]
resp_valid  out  1  one-cycle pulse: response available
resp_id  out  $clog2(NUM_REQ) (min 1)  requester that owns the response
resp_result  out  OUTPUT_WIDTH  Fibonacci result; 0 on error
resp_overflow  out  1  overflow flag from unit; 0 on error
resp_error  out  1  timeout occurred
busy  out  1  high in every state except IDLE
fib_go  out  1  go to fib unit
fib_n  out  INPUT_WIDTH  n to fib unit
fib_result  in  OUTPUT_WIDTH  from fib unit
fib_overflow  in  1  from fib unit
fib_done  in  1  from fib unit; stays high until the cycle after go

Behaviour:
- Reset (rst_n=0, async): state=IDLE; all outputs 0; rr pointer=0; latched id/n/result=0; timeout counter=0.
- States: IDLE, ISSUE, WAIT_CLR, WAIT_DONE, RESP.
- IDLE:
  - If any req bit is set, grant the first set bit at or after pointer, wrapping modulo NUM_REQ.
  - Latch id and that requester's n.
  - Set pointer=(id+1) mod NUM_REQ, then go to ISSUE.
  - If no req is set, stay in IDLE with the pointer unchanged.
- ISSUE: fib_go=1 for exactly this one cycle, then go to WAIT_CLR; clear the timeout counter.
- fib_n: driven with the latched n from ISSUE through WAIT_DONE; held at its last value otherwise.
- WAIT_CLR: stay until fib_done==0, then go to WAIT_DONE.
  - Required because done from the previous job is still high in the cycle after go.
  - A stale done must never be accepted.
- WAIT_DONE: on fib_done==1, capture fib_result/fib_overflow and go to RESP.
- Timeout counter: increments every cycle in WAIT_CLR/WAIT_DONE.
  - When it reaches TIMEOUT_CYCLES-1 without completion, go to RESP with error set and result/overflow forced 0.
  - Completion and timeout in the same cycle: completion wins, no error.
- RESP: resp_valid=1 for one cycle, with resp_id/result/overflow/error; then go to IDLE.
  - resp_* data registered; holds its value until the next RESP.
- Response latency: from IDLE grant to resp_valid = 3 + (cycles in WAIT_CLR) + (cycles in WAIT_DONE, >=1).
- Requester contract: must drop req in the cycle after its resp_valid.
  - If req is still high in IDLE, it is re-granted only per round-robin order, so no starvation.
- Changes to req_n after grant have no effect on the job in flight.
- Deasserting req mid-job: the job completes and its response is still issued.
- Only one job in flight; fib_go never asserts outside ISSUE.
- Reset mid-job: returns to IDLE immediately with no response; fib_go=0.
  - The fib unit's own reset is separate; the next ISSUE proceeds normally.

Test Plan:
- Bench uses a stub fib: done clears 1 cycle after go, result=n+100 after L cycles; stub done=1 at start.
- Single request: req=0001, n0=10, L=5 -> one fib_go pulse; resp_valid with id=0, result=110, overflow=0, error=0; stale done not accepted.
- All four req high, n_i=i: grant order 0,1,2,3,0 -> results 100,101,102,103,100, one resp per job, never two go pulses in flight.
- Round-robin fairness: req0 held high permanently, req2 asserted -> req2 served within 2 jobs; pointer wraps from 3 to 0.
- Timeout: stub never raises done, TIMEOUT_CYCLES=16 -> resp_valid 16 cycles after WAIT_CLR entry (incl. clear) with error=1, result=0; next job is served normally.
- Overflow passthrough and reset: stub drives overflow=1 -> resp_overflow=1. rst_n low during WAIT_DONE -> busy=0, no resp_valid; after release, a new req completes normally.
